// File: rtl/data_mem_pkg.sv
// Shared types and store-strobe legality rules for the data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] STRB_B0 = 4'b0001;
    localparam logic [3:0] STRB_B1 = 4'b0010;
    localparam logic [3:0] STRB_B2 = 4'b0100;
    localparam logic [3:0] STRB_B3 = 4'b1000;
    localparam logic [3:0] STRB_H0 = 4'b0011;
    localparam logic [3:0] STRB_H1 = 4'b1100;
    localparam logic [3:0] STRB_W  = 4'b1111;

    // A strobe is legal only in its shape set and only at the matching byte offset.
    function automatic logic strb_legal(
        input logic [3:0] wstrb,
        input logic [1:0] addr_lo
    );
        logic ok;
        case (wstrb)
            STRB_B0: ok = (addr_lo == 2'd0);
            STRB_B1: ok = (addr_lo == 2'd1);
            STRB_B2: ok = (addr_lo == 2'd2);
            STRB_B3: ok = (addr_lo == 2'd3);
            STRB_H0: ok = (addr_lo == 2'd0);
            STRB_H1: ok = (addr_lo == 2'd2);
            STRB_W:  ok = (addr_lo == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_resp_array.sv
// Single-port word RAM with byte-enabled write and registered read.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_wstrb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we && i_wstrb[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, then
// commits the store or returns the load word, stalling the pipeline meanwhile.
module data_mem_resp
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT =
        ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_valid;
    logic        r_err;
    logic        r_rd_ok;

    logic        w_ready;
    logic        w_acc;
    logic        w_fire;
    logic        w_we;
    logic [3:0]  w_wstrb;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic        w_mem_en;
    logic [31:0] w_rdata;

    assign w_ready = (r_state != ST_WAIT);
    assign w_acc   = req_en & w_ready;

    // With no wait states the access happens on the acceptance edge itself,
    // so it must use the live request rather than the latched copy.
    assign w_fire  = ZERO_WAIT ? w_acc
                               : (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_we    = ZERO_WAIT ? req_we    : r_we;
    assign w_wstrb = ZERO_WAIT ? req_wstrb : r_wstrb;
    assign w_addr  = ZERO_WAIT ? req_addr  : r_addr;
    assign w_wdata = ZERO_WAIT ? req_wdata : r_wdata;

    assign w_err = (|w_addr[31:ADDR_W+2])
                 | (w_we & ~strb_legal(w_wstrb, w_addr[1:0]));

    assign w_mem_en = w_fire & ~w_err & ~rst;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_we),
        .i_wstrb (w_wstrb),
        .i_addr  (w_addr[ADDR_W+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_we    <= req_we;
            r_wstrb <= req_wstrb;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            r_valid <= w_fire;
            r_err   <= w_fire & w_err;
            r_rd_ok <= w_fire & ~w_err & ~w_we;
            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    if (req_en) begin
                        r_cnt   <= CNT_INIT;
                        r_state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_valid;
    assign rsp_err   = r_err;
    assign rsp_rdata = r_rd_ok ? w_rdata : 32'd0;
    assign stall     = (r_state == ST_WAIT) | w_acc;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed and randomized checks of data_mem_resp against a word-array model.
module tb_data_mem_resp;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, a_we;
    logic [3:0]  a_wstrb;
    logic [31:0] a_addr, a_wdata;
    logic        a_ready, a_valid, a_err, a_stall;
    logic [31:0] a_rdata;

    logic        b_en, b_we;
    logic [3:0]  b_wstrb;
    logic [31:0] b_addr, b_wdata;
    logic        b_ready, b_valid, b_err, b_stall;
    logic [31:0] b_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];

    data_mem_resp #(.ADDR_W(AW), .WAIT_CYCLES(LAT)) dut_a (
        .clk(clk), .rst(rst),
        .req_en(a_en), .req_we(a_we), .req_wstrb(a_wstrb),
        .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .rsp_valid(a_valid),
        .rsp_rdata(a_rdata), .rsp_err(a_err), .stall(a_stall)
    );

    data_mem_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_en(b_en), .req_we(b_we), .req_wstrb(b_wstrb),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .rsp_valid(b_valid),
        .rsp_rdata(b_rdata), .rsp_err(b_err), .stall(b_stall)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Error rules restated as shape/alignment arithmetic.
    function automatic bit model_err(input bit we, input logic [3:0] s,
                                     input logic [31:0] a);
        int n;
        int lo;
        if ((a >> (AW + 2)) != 0) return 1'b1;
        if (!we) return 1'b0;
        n = $countones(s);
        if (!(n == 1 || n == 2 || n == 4)) return 1'b1;
        lo = 0;
        for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
        if (s != 4'(((1 << n) - 1) << lo)) return 1'b1;
        if (lo != int'(a[1:0])) return 1'b1;
        if ((lo % n) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_a(input bit we, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] d,
                           output bit e, output logic [31:0] r);
        int w;
        logic [31:0] v;
        w = int'(a[AW+1:2]);
        e = model_err(we, s, a);
        r = 32'd0;
        if (!e) begin
            if (we) begin
                v = mem_a.exists(w) ? mem_a[w] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (s[i]) v[8*i +: 8] = d[8*i +: 8];
                mem_a[w] = v;
            end else begin
                r = mem_a.exists(w) ? mem_a[w] : 32'd0;
            end
        end
    endtask

    // One isolated request on dut_a; entered and left just after a rising edge.
    task automatic txn(input bit we, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        bit ee;
        logic [31:0] er;
        model_a(we, s, a, d, ee, er);
        a_en = 1'b1; a_we = we; a_wstrb = s; a_addr = a; a_wdata = d;
        @(negedge clk);
        chk({tag, ".stall_req"}, 32'(a_stall), 32'd1);
        @(posedge clk); #1;
        a_en = 1'b0; a_addr = $urandom; a_wdata = $urandom;
        a_wstrb = 4'($urandom); a_we = 1'($urandom);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk({tag, ".wait_valid"}, 32'(a_valid), 32'd0);
            chk({tag, ".wait_stall"}, 32'(a_stall), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, ".valid"}, 32'(a_valid), 32'd1);
        chk({tag, ".err"}, 32'(a_err), 32'(ee));
        chk({tag, ".rdata"}, a_rdata, er);
        chk({tag, ".resp_stall"}, 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".idle_valid"}, 32'(a_valid), 32'd0);
        chk({tag, ".idle_rdata"}, a_rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    logic [3:0] leg_s [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    int         leg_l [7] = '{0, 1, 2, 3, 0, 2, 0};

    initial begin
        bit e1, e2, pe_err;
        logic [31:0] r1, r2, pe_rd, addr;
        logic [3:0] s;
        int w, lo, k;
        bit we;

        rst = 1'b1;
        a_en = 0; a_we = 0; a_wstrb = 0; a_addr = 0; a_wdata = 0;
        b_en = 0; b_we = 0; b_wstrb = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.ready", 32'(a_ready), 32'd1);
        chk("reset.valid", 32'(a_valid), 32'd0);
        chk("reset.rdata", a_rdata, 32'd0);
        chk("reset.err", 32'(a_err), 32'd0);
        chk("reset.stall", 32'(a_stall), 32'd0);
        @(posedge clk); #1;

        txn(1, 4'hF, 32'h10, 32'hDEADBEEF, "st10");
        txn(0, 4'h0, 32'h10, 32'h0, "ld10");
        txn(1, 4'hF, 32'h10, 32'h11223344, "st10b");
        txn(1, 4'h4, 32'h12, 32'h00AA0000, "stbyte12");
        txn(0, 4'h0, 32'h10, 32'h0, "ld10merge");

        // Back-to-back: store then load with req_en held through RESP.
        model_a(1, 4'hF, 32'h20, 32'h5, e1, r1);
        model_a(0, 4'h0, 32'h20, 32'h0, e2, r2);
        a_en = 1; a_we = 1; a_wstrb = 4'hF; a_addr = 32'h20; a_wdata = 32'h5;
        @(posedge clk); #1;
        a_we = 0; a_wdata = 32'h0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("b2b.w1_valid", 32'(a_valid), 32'd0);
            chk("b2b.w1_ready", 32'(a_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b2b.st_valid", 32'(a_valid), 32'd1);
        chk("b2b.st_err", 32'(a_err), 32'(e1));
        chk("b2b.st_rdata", a_rdata, r1);
        chk("b2b.st_stall", 32'(a_stall), 32'd1);
        @(posedge clk); #1;
        a_en = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("b2b.w2_valid", 32'(a_valid), 32'd0);
            chk("b2b.w2_ready", 32'(a_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b2b.ld_valid", 32'(a_valid), 32'd1);
        chk("b2b.ld_err", 32'(a_err), 32'(e2));
        chk("b2b.ld_rdata", a_rdata, r2);
        @(posedge clk); #1;

        // Error cases, then confirm memory untouched.
        txn(1, 4'hF, 32'h0, 32'h0BADF00D, "st00");
        txn(1, 4'hF, 32'h0010_0000, 32'h99999999, "err_oor");
        txn(0, 4'h0, 32'h0010_0010, 32'h0, "err_oor_ld");
        txn(1, 4'h6, 32'h11, 32'h00FFFF00, "err_0110");
        txn(1, 4'h3, 32'h13, 32'h0000FFFF, "err_h_mis");
        txn(1, 4'hF, 32'h02, 32'hFFFFFFFF, "err_w_mis");
        txn(1, 4'h0, 32'h10, 32'hFFFFFFFF, "err_0000");
        txn(0, 4'h0, 32'h10, 32'h0, "ld10_after_err");
        txn(0, 4'h0, 32'h00, 32'h0, "ld00_after_err");

        // Reset one cycle after accepting a store: it must be abandoned.
        txn(1, 4'hF, 32'h30, 32'hCAFE0001, "st30");
        a_en = 1; a_we = 1; a_wstrb = 4'hF;
        a_addr = 32'h30; a_wdata = 32'h12345678;
        @(posedge clk); #1;
        a_en = 0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid.valid", 32'(a_valid), 32'd0);
            chk("rstmid.ready", 32'(a_ready), 32'd1);
            @(posedge clk); #1;
        end
        txn(0, 4'h0, 32'h30, 32'h0, "ld30_after_rst");

        // Random traffic over a pre-filled pool of 16 words.
        for (int i = 0; i < 16; i++)
            txn(1, 4'hF, 32'(i * 4), $urandom, "fill");
        for (int i = 0; i < 40; i++) begin
            w  = $urandom_range(0, 15);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 6);
                s = leg_s[k]; lo = leg_l[k];
            end else begin
                s = 4'($urandom); lo = $urandom_range(0, 3);
            end
            addr = 32'(w * 4 + lo);
            if ($urandom_range(0, 7) == 0)
                addr = addr | (32'($urandom_range(1, 1000)) << 12);
            txn(we, s, addr, $urandom, "rand");
        end

        // Zero-wait instance: one response per cycle with req_en held.
        pe_err = 0; pe_rd = 0;
        for (int i = 0; i < 20; i++) begin
            bit e;
            logic [31:0] r;
            int op;
            w  = (i < 4) ? i : $urandom_range(0, 3);
            op = (i < 4) ? 1 : $urandom_range(0, 2);
            b_en = 1; b_wstrb = 4'hF; b_wdata = $urandom;
            b_we = (op == 1);
            b_addr = 32'(w * 4);
            if (op == 2) b_addr = b_addr | 32'h0000_8000;
            e = (op == 2);
            r = 32'd0;
            if (op == 1) mem_b[w] = b_wdata;
            if (op == 0) r = mem_b[w];
            @(negedge clk);
            chk("zw.stall", 32'(b_stall), 32'd1);
            if (i > 0) begin
                chk("zw.valid", 32'(b_valid), 32'd1);
                chk("zw.err", 32'(b_err), 32'(pe_err));
                chk("zw.rdata", b_rdata, pe_rd);
            end
            pe_err = e; pe_rd = r;
            @(posedge clk); #1;
        end
        b_en = 0;
        @(negedge clk);
        chk("zw.last_valid", 32'(b_valid), 32'd1);
        chk("zw.last_err", 32'(b_err), 32'(pe_err));
        chk("zw.last_rdata", b_rdata, pe_rd);
        chk("zw.last_stall", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zw.idle_valid", 32'(b_valid), 32'd0);
        chk("zw.idle_rdata", b_rdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
